// File: rtl/pll_cmd_pkg.sv
// rtl/pll_cmd_pkg.sv - opcodes, reply codes, state encoding and status bit map for pll_cmd_decoder
package pll_cmd_pkg;

  localparam logic [7:0] CMD_SET_PHASE  = 8'h0A;
  localparam logic [7:0] CMD_SET_CLKSRC = 8'h0B;
  localparam logic [7:0] CMD_APPLY      = 8'h0C;
  localparam logic [7:0] CMD_GET_PHASE  = 8'h0D;
  localparam logic [7:0] CMD_STATUS     = 8'h0E;

  localparam logic [7:0] RPL_ACK      = 8'hA5;
  localparam logic [7:0] RPL_LOCK_ERR = 8'hEE;
  localparam logic [7:0] RPL_BAD_CMD  = 8'hEF;

  localparam int STAT_OVERRUN  = 7;
  localparam int STAT_LOCK_ERR = 6;
  localparam int STAT_CLKSRC   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ARG,
    ST_APPLY,
    ST_HOLDOFF,
    ST_LOCKWAIT,
    ST_REPLY
  } state_t;

endpackage

// File: rtl/pll_cmd_decoder.sv
// rtl/pll_cmd_decoder.sv - host byte-command decoder that sets PLL phase/clock source and paces update, lock check and reply
module pll_cmd_decoder
  import pll_cmd_pkg::*;
#(
  parameter int unsigned HOLDOFF_CYCLES = 524288,
  parameter int unsigned LOCK_TIMEOUT   = 1000000,
  parameter int unsigned LOCK_STABLE    = 16,
  parameter int unsigned BYTE_TIMEOUT   = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tx_ready,
  input  logic       pll_locked,
  output logic       update,
  output logic       pll_clksrc,
  output logic [7:0] pll_phase,
  output logic       busy,
  output logic [7:0] tx_data,
  output logic       tx_valid
);

  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int BW = $clog2(BYTE_TIMEOUT + 1);

  localparam logic [HW-1:0] HOLD_MAX    = HW'(HOLDOFF_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLDOFF_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_MAX    = LW'(LOCK_TIMEOUT);
  localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STABLE_MAX  = SW'(LOCK_STABLE);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE - 1);
  localparam logic [BW-1:0] BYTE_MAX    = BW'(BYTE_TIMEOUT);
  localparam logic [BW-1:0] BYTE_LAST   = BW'(BYTE_TIMEOUT - 1);

  state_t state, state_next;

  logic [HW-1:0] hold_cnt;
  logic [LW-1:0] lock_cnt;
  logic [SW-1:0] stable_cnt;
  logic [BW-1:0] byte_cnt;

  logic       overrun;
  logic       lock_err;
  logic       arg_is_clksrc;
  logic       reply_is_status;
  logic       lock_ok;
  logic       lock_tmo;
  logic [7:0] status;

  assign update   = (state == ST_APPLY);
  assign tx_valid = (state == ST_REPLY);
  assign busy     = (state == ST_APPLY) || (state == ST_HOLDOFF) ||
                    (state == ST_LOCKWAIT) || (state == ST_REPLY);

  always_comb begin
    status                = '0;
    status[STAT_OVERRUN]  = overrun;
    status[STAT_LOCK_ERR] = lock_err;
    status[STAT_CLKSRC]   = pll_clksrc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    lock_ok    = 1'b0;
    lock_tmo   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_SET_PHASE || rx_data == CMD_SET_CLKSRC) state_next = ST_GET_ARG;
          else if (rx_data == CMD_APPLY)                             state_next = ST_APPLY;
          else                                                       state_next = ST_REPLY;
        end
      end
      ST_GET_ARG: begin
        if (rx_valid || byte_cnt == BYTE_LAST) state_next = ST_IDLE;
      end
      ST_APPLY:   state_next = ST_HOLDOFF;
      // hold_cnt already counted the APPLY cycle, so LOCKWAIT lands HOLDOFF_CYCLES after update
      ST_HOLDOFF: begin
        if (hold_cnt == HOLD_LAST) state_next = ST_LOCKWAIT;
      end
      ST_LOCKWAIT: begin
        if (pll_locked && stable_cnt == STABLE_LAST) begin
          lock_ok    = 1'b1;
          state_next = ST_REPLY;
        end else if (lock_cnt == LOCK_LAST) begin
          lock_tmo   = 1'b1;
          state_next = ST_REPLY;
        end
      end
      ST_REPLY: begin
        if (tx_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt        <= '0;
      lock_cnt        <= '0;
      stable_cnt      <= '0;
      byte_cnt        <= '0;
      pll_phase       <= '0;
      pll_clksrc      <= 1'b0;
      tx_data         <= '0;
      overrun         <= 1'b0;
      lock_err        <= 1'b0;
      arg_is_clksrc   <= 1'b0;
      reply_is_status <= 1'b0;
    end else begin
      if (state == ST_GET_ARG) begin
        if (byte_cnt != BYTE_MAX) byte_cnt <= byte_cnt + BW'(1);
      end else byte_cnt <= '0;

      if (state == ST_APPLY || state == ST_HOLDOFF) begin
        if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
      end else hold_cnt <= '0;

      if (state == ST_LOCKWAIT) begin
        if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + LW'(1);
      end else lock_cnt <= '0;

      if (state == ST_LOCKWAIT && pll_locked) begin
        if (stable_cnt != STABLE_MAX) stable_cnt <= stable_cnt + SW'(1);
      end else stable_cnt <= '0;

      case (state)
        ST_IDLE: begin
          if (rx_valid) begin
            arg_is_clksrc   <= (rx_data == CMD_SET_CLKSRC);
            reply_is_status <= (rx_data == CMD_STATUS);
            if (rx_data == CMD_GET_PHASE)   tx_data <= pll_phase;
            else if (rx_data == CMD_STATUS) tx_data <= status;
            else if (rx_data < CMD_SET_PHASE || rx_data > CMD_STATUS) tx_data <= RPL_BAD_CMD;
          end
        end
        ST_GET_ARG: begin
          if (rx_valid) begin
            if (arg_is_clksrc) pll_clksrc <= rx_data[0];
            else               pll_phase  <= rx_data;
          end
        end
        ST_LOCKWAIT: begin
          if (lock_ok) begin
            tx_data  <= RPL_ACK;
            lock_err <= 1'b0;
          end else if (lock_tmo) begin
            tx_data  <= RPL_LOCK_ERR;
            lock_err <= 1'b1;
          end
        end
        ST_REPLY: begin
          if (tx_ready && reply_is_status) begin
            overrun  <= 1'b0;
            lock_err <= 1'b0;
          end
        end
        default: ;
      endcase

      // a byte arriving while busy is lost; this wins over the status-read clear
      if (rx_valid && busy) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pll_cmd_decoder.sv
// tb/tb_pll_cmd_decoder.sv - randomized self-checking bench for pll_cmd_decoder against a command-level model
module tb_pll_cmd_decoder;

  localparam int H  = 20;
  localparam int T  = 60;
  localparam int S  = 4;
  localparam int BT = 30;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;
  logic       pll_locked = 1'b0;
  logic       update, pll_clksrc, busy, tx_valid;
  logic [7:0] pll_phase, tx_data;

  pll_cmd_decoder #(
    .HOLDOFF_CYCLES(H), .LOCK_TIMEOUT(T), .LOCK_STABLE(S), .BYTE_TIMEOUT(BT)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_ready(tx_ready), .pll_locked(pll_locked), .update(update),
    .pll_clksrc(pll_clksrc), .pll_phase(pll_phase), .busy(busy),
    .tx_data(tx_data), .tx_valid(tx_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int upd_count = 0;
  int upd_cyc = 0;
  always @(negedge clk) if (update === 1'b1) begin upd_count++; upd_cyc = cyc; end

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] m_phase = 8'h00;
  logic       m_cs = 1'b0, m_ov = 1'b0, m_le = 1'b0;

  function automatic logic [7:0] m_status();
    return {m_ov, m_le, 5'b00000, m_cs};
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_data = 8'($urandom);
  endtask

  task automatic take_reply(output logic got, output logic [7:0] data, output int rcyc,
                            output logic held, output logic released);
    int waited = 0;
    while (tx_valid !== 1'b1 && waited < H + T + 40) begin @(negedge clk); waited++; end
    got = (tx_valid === 1'b1); data = tx_data; rcyc = cyc; held = 1'b1;
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      if (tx_valid !== 1'b1 || tx_data !== data) held = 1'b0;
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    released = (tx_valid === 1'b0) && (busy === 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if ({update, pll_clksrc, busy, tx_valid} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_ctl: update/clksrc/busy/tx_valid=%b required 0000", {update, pll_clksrc, busy, tx_valid}); end
    n_checks++; if (pll_phase !== 8'h00 || tx_data !== 8'h00) begin n_fail++;
      $display("FAIL reset_data: phase=%h tx_data=%h required 00 00", pll_phase, tx_data); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_set_phase();
    logic got, held, released; logic [7:0] data; int rcyc, base;
    for (int k = 0; k < 6; k++) begin
      logic [7:0] p;
      p = (k == 0) ? 8'h37 : 8'($urandom);
      base = upd_count;
      send_byte(8'h0A);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_byte(p);
      m_phase = p;
      n_checks++; if (pll_phase !== m_phase) begin n_fail++;
        $display("FAIL set_phase: pll_phase=%h required %h", pll_phase, m_phase); end
      send_byte(8'h0D);
      n_checks++; if (tx_valid !== 1'b1) begin n_fail++;
        $display("FAIL get_phase_latency: tx_valid=%b required 1", tx_valid); end
      take_reply(got, data, rcyc, held, released);
      n_checks++; if (!(got && held && released) || data !== m_phase) begin n_fail++;
        $display("FAIL get_phase_reply: got=%b held=%b rel=%b data=%h required %h", got, held, released, data, m_phase); end
      n_checks++; if (upd_count !== base) begin n_fail++;
        $display("FAIL get_phase_no_update: updates=%0d required %0d", upd_count - base, 0); end
    end
  endtask

  task automatic test_apply_lock();
    logic got, held, released; logic [7:0] data; int rcyc;
    send_byte(8'h0B); send_byte(8'h01); m_cs = 1'b1;
    pll_locked = 1'b1;
    send_byte(8'h0C);
    n_checks++; if (update !== 1'b1 || busy !== 1'b1 || pll_clksrc !== 1'b1) begin n_fail++;
      $display("FAIL apply_start: update=%b busy=%b clksrc=%b required 1 1 1", update, busy, pll_clksrc); end
    @(negedge clk);
    n_checks++; if (update !== 1'b0) begin n_fail++;
      $display("FAIL apply_one_cycle: update=%b required 0", update); end
    take_reply(got, data, rcyc, held, released);
    m_le = 1'b0;
    n_checks++; if (!(got && held && released) || data !== 8'hA5) begin n_fail++;
      $display("FAIL apply_ack: got=%b held=%b rel=%b data=%h required a5", got, held, released, data); end
    n_checks++; if (rcyc - upd_cyc !== H + S) begin n_fail++;
      $display("FAIL apply_latency: cycles=%0d required %0d", rcyc - upd_cyc, H + S); end
    n_checks++; if (pll_clksrc !== m_cs || pll_phase !== m_phase) begin n_fail++;
      $display("FAIL apply_hold: clksrc=%b phase=%h required %b %h", pll_clksrc, pll_phase, m_cs, m_phase); end
  endtask

  task automatic test_lock_timeout();
    logic got, held, released; logic [7:0] data; int rcyc;
    send_byte(8'h0B); send_byte(8'h00); m_cs = 1'b0;
    pll_locked = 1'b0;
    send_byte(8'h0C);
    fork
      begin
        repeat (H + 2) @(negedge clk);
        pll_locked = 1'b1;
        repeat (S - 1) @(negedge clk);
        pll_locked = 1'b0;
      end
    join_none
    take_reply(got, data, rcyc, held, released);
    m_le = 1'b1;
    n_checks++; if (!(got && held && released) || data !== 8'hEE) begin n_fail++;
      $display("FAIL timeout_reply: got=%b held=%b rel=%b data=%h required ee", got, held, released, data); end
    n_checks++; if (rcyc - upd_cyc !== H + T) begin n_fail++;
      $display("FAIL timeout_latency: cycles=%0d required %0d", rcyc - upd_cyc, H + T); end
    for (int k = 0; k < 2; k++) begin
      logic [7:0] exp;
      exp = m_status();
      send_byte(8'h0E);
      take_reply(got, data, rcyc, held, released);
      m_ov = 1'b0; m_le = 1'b0;
      n_checks++; if (!(got && released) || data !== exp) begin n_fail++;
        $display("FAIL timeout_status%0d: got=%b data=%h required %h", k, got, data, exp); end
    end
  endtask

  task automatic test_byte_timeout();
    logic got, held, released; logic [7:0] data, p; int rcyc;
    p = 8'($urandom);
    send_byte(8'h0A);
    repeat (BT - 2) @(negedge clk);
    send_byte(p);
    m_phase = p;
    n_checks++; if (pll_phase !== m_phase || busy !== 1'b0) begin n_fail++;
      $display("FAIL late_arg: phase=%h busy=%b required %h 0", pll_phase, busy, m_phase); end
    send_byte(8'h0A);
    repeat (BT + 3) @(negedge clk);
    send_byte(8'h05);
    n_checks++; if (tx_valid !== 1'b1) begin n_fail++;
      $display("FAIL byte_timeout_latency: tx_valid=%b required 1", tx_valid); end
    take_reply(got, data, rcyc, held, released);
    n_checks++; if (!(got && held && released) || data !== 8'hEF) begin n_fail++;
      $display("FAIL byte_timeout_reply: data=%h required ef", data); end
    n_checks++; if (pll_phase !== m_phase) begin n_fail++;
      $display("FAIL byte_timeout_phase: phase=%h required %h", pll_phase, m_phase); end
  endtask

  task automatic test_overrun();
    logic got, held, released; logic [7:0] data, exp; int rcyc;
    pll_locked = 1'b1;
    send_byte(8'h0C);
    repeat (3) @(negedge clk);
    send_byte(8'h0D);
    m_ov = 1'b1;
    take_reply(got, data, rcyc, held, released);
    m_le = 1'b0;
    n_checks++; if (!(got && held && released) || data !== 8'hA5) begin n_fail++;
      $display("FAIL overrun_ack: got=%b rel=%b data=%h required a5", got, released, data); end
    exp = m_status();
    send_byte(8'h0E);
    take_reply(got, data, rcyc, held, released);
    m_ov = 1'b0; m_le = 1'b0;
    n_checks++; if (!(got && released) || data !== exp) begin n_fail++;
      $display("FAIL overrun_status: data=%h required %h", data, exp); end
    send_byte(8'h0D);
    n_checks++; if (tx_valid !== 1'b1 || tx_data !== m_phase) begin n_fail++;
      $display("FAIL reply_edge_data: tx_valid=%b data=%h required 1 %h", tx_valid, tx_data, m_phase); end
    tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'h0D;
    @(negedge clk);
    tx_ready = 1'b0; rx_valid = 1'b0;
    m_ov = 1'b1;
    n_checks++; if (tx_valid !== 1'b0 || busy !== 1'b0) begin n_fail++;
      $display("FAIL reply_edge_drop: tx_valid=%b busy=%b required 0 0", tx_valid, busy); end
    exp = m_status();
    send_byte(8'h0E);
    take_reply(got, data, rcyc, held, released);
    m_ov = 1'b0; m_le = 1'b0;
    n_checks++; if (!(got && released) || data !== exp) begin n_fail++;
      $display("FAIL reply_edge_status: data=%h required %h", data, exp); end
  endtask

  task automatic test_back_to_back();
    logic got, held, released; logic [7:0] data, exp, b; int rcyc, op;
    pll_locked = 1'b1;
    for (int k = 0; k < 24; k++) begin
      op = $urandom_range(0, 5);
      b = 8'($urandom);
      case (op)
        0: begin send_byte(8'h0A); send_byte(b); m_phase = b; end
        1: begin send_byte(8'h0B); send_byte(b); m_cs = b[0]; end
        default: begin
          if (op == 2)      begin exp = m_phase; send_byte(8'h0D); end
          else if (op == 3) begin exp = m_status(); send_byte(8'h0E); end
          else if (op == 4) begin
            while (b >= 8'h0A && b <= 8'h0E) b = 8'($urandom);
            exp = 8'hEF; send_byte(b);
          end else begin exp = 8'hA5; send_byte(8'h0C); end
          take_reply(got, data, rcyc, held, released);
          if (op == 3) begin m_ov = 1'b0; m_le = 1'b0; end
          if (op == 5) m_le = 1'b0;
          n_checks++; if (!(got && held && released) || data !== exp) begin n_fail++;
            $display("FAIL b2b_op%0d_step%0d: got=%b held=%b rel=%b data=%h required %h", op, k, got, held, released, data, exp); end
        end
      endcase
      n_checks++; if (pll_phase !== m_phase || pll_clksrc !== m_cs) begin n_fail++;
        $display("FAIL b2b_regs_step%0d: phase=%h clksrc=%b required %h %b", k, pll_phase, pll_clksrc, m_phase, m_cs); end
    end
  endtask

  task automatic test_reset_mid();
    logic got, held, released; logic [7:0] data; int rcyc;
    send_byte(8'h0A); send_byte(8'h5A);
    send_byte(8'h0B); send_byte(8'h01);
    pll_locked = 1'b0;
    send_byte(8'h0C);
    repeat (H + 5) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if ({update, pll_clksrc, busy, tx_valid} !== 4'b0000 || pll_phase !== 8'h00 || tx_data !== 8'h00) begin n_fail++;
      $display("FAIL mid_reset: ctl=%b phase=%h tx_data=%h required 0000 00 00",
               {update, pll_clksrc, busy, tx_valid}, pll_phase, tx_data); end
    @(negedge clk);
    reset = 1'b0;
    m_phase = 8'h00; m_cs = 1'b0; m_ov = 1'b0; m_le = 1'b0;
    @(negedge clk);
    send_byte(8'h0D);
    take_reply(got, data, rcyc, held, released);
    n_checks++; if (!(got && released) || data !== 8'h00) begin n_fail++;
      $display("FAIL mid_reset_phase: got=%b data=%h required 00", got, data); end
  endtask

  initial begin
    test_reset();
    test_set_phase();
    test_apply_lock();
    test_lock_timeout();
    test_byte_timeout();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
